// File: rtl/des_sbox_stage.sv
// DES substitution stage: S1..S_NUM_BOX over a 6*NUM_BOX-bit word.
// Parallel single-cycle mode or a serial mode sharing one lookup unit.
module des_sbox_stage #(
    parameter int NUM_BOX = 8,
    parameter int SERIAL  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:6*NUM_BOX]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [1:4*NUM_BOX]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int IW = 6 * NUM_BOX;
    localparam int OW = 4 * NUM_BOX;
    localparam logic [3:0] LAST = 4'(NUM_BOX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One nibble per entry, entry 0 (row 0, col 0) in the top nibble.
    localparam logic [255:0] SBOX_TBL [0:7] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_f(input logic [2:0] k,
                                          input logic [5:0] b);
        logic [5:0]   ent;
        logic [255:0] t;
        ent = {b[5], b[0], b[4:1]};
        t   = SBOX_TBL[k] >> {6'd63 - ent, 2'b00};
        return t[3:0];
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:IW] in_q, in_d;
    logic [1:OW] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [1:OW] par_res;
    logic [3:0]  ser_res;
    logic        in_ready_c, busy_c;
    int          ser_k;

    always_comb begin
        par_res = '0;
        for (int k = 0; k < NUM_BOX; k++) begin
            par_res[4*k+1 +: 4] = sbox_f(3'(k), in_data[6*k+1 +: 6]);
        end
    end

    // Clamp keeps the shared unit's selects in range outside BUSY.
    always_comb begin
        ser_k = 0;
        if (idx_q != 4'd0 && idx_q <= LAST) begin
            ser_k = int'(idx_q) - 1;
        end
        ser_res = sbox_f(3'(ser_k), in_q[6*ser_k+1 +: 6]);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_d        = in_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_c  = 1'b0;
        busy_c      = 1'b0;
        if (SERIAL == 0) begin
            in_ready_c = !rst && (!out_valid_q || out_ready);
            if (in_valid && in_ready_c) begin
                out_data_d  = par_res;
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end else begin
            busy_c     = (state_q == ST_BUSY);
            in_ready_c = !rst && (state_q == ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_c) begin
                        in_d       = in_data;
                        idx_d      = 4'd1;
                        out_data_d = '0;
                        state_d    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    out_data_d[4*ser_k+1 +: 4] = ser_res;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            in_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_q        <= in_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign busy      = busy_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/des_sbox_stage.md
Name: des_sbox_stage

Overview:
- Parametrised DES substitution stage: applies S-boxes S1..S_NUM_BOX to a 6*NUM_BOX-bit word and produces a 4*NUM_BOX-bit result.
- Sits between the E-expansion/key-XOR and the P-permutation of the round function.
- Successor to the single combinational S-box: multi-box, registered output, valid/ready handshake, and a selectable area-saving serial mode that reuses one lookup unit.

Parameters:
- NUM_BOX, 8, number of S-boxes applied (1..8); lane k uses DES table Sk.
- SERIAL, 0, 0 = all boxes in parallel with one-cycle latency; 1 = one shared lookup unit, one box per cycle.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  [1:6*NUM_BOX]  box k input = bits 6k-5..6k.
- in_valid  input  1  in_data valid.
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
- out_data  output  [1:4*NUM_BOX]  box k result = bits 4k-3..4k.
- out_valid  output  1  out_data holds a complete result.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- busy  output  1  serial mode computing (always 0 when SERIAL=0).

Behaviour:
- Lookup per box, for 6-bit input b[1:6]:
  - row = {b1,b6}, col = b[2:5].
  - Output = standard DES table entry, MSB at lowest index.
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, busy=0, serial FSM to IDLE, box counter=0.
  - Overrides any in-flight word, which is discarded; no partial result is ever presented.
  - in_ready is 0 during the reset cycle.
- SERIAL=0:
  - in_ready = !out_valid || out_ready.
  - On accept, out_data is loaded with all box results and out_valid=1 at the next edge (latency 1).
  - On an out transfer with no new accept, out_valid clears.
  - Simultaneous out transfer and accept: out_data is replaced and out_valid stays 1, giving one word per cycle.
  - out_data is held stable while out_valid && !out_ready.
- SERIAL=1, FSM IDLE -> BUSY -> DONE:
  - IDLE: in_ready=1, busy=0. Accept captures in_data into an input register, clears idx to 1, goes to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, box idx is looked up with table S_idx and its 4 bits are written into the output register at 4idx-3..4idx, then idx increments. After writing idx=NUM_BOX, go to DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready=1, out_valid clears and the FSM goes to IDLE. No accept is taken in the same cycle.
  - Latency: out_valid rises NUM_BOX edges after the accept edge.
  - Throughput: one word per NUM_BOX+2 cycles minimum.
  - out_data is zeroed on accept and stays hidden (out_valid=0) until DONE.
  - in_valid during BUSY/DONE is ignored; the producer holds in_data.
- NUM_BOX=1 serial: BUSY lasts exactly one cycle.
- out_data width and contents are independent of SERIAL; both modes give bit-identical results for the same input.

Test Plan:
- NUM_BOX=8, SERIAL=0: in_data=48'h0 -> one edge later out_valid=1, out_data=32'hEFA72C4D.
- NUM_BOX=8, SERIAL=0: all-ones input -> 32'hD9CE3DCB.
  - Then back-to-back accepts with out_ready=1 for 16 cycles of random data -> one result per cycle, in_ready constantly 1, matches the golden DES model.
- SERIAL=0 backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data unchanged.
  - On out_ready=1, the pending word transfers and the next word is accepted the same cycle.
- NUM_BOX=8, SERIAL=1: in_data=48'h0 -> busy=1 for 8 cycles, out_valid=1 at accept+8, out_data=32'hEFA72C4D, in_ready=0 until the out transfer.
- NUM_BOX=1: sweep all 64 inputs in both modes -> outputs equal the S1 table (e.g. 6'b000000->14, 6'b000001->0, 6'b100000->4, 6'b111111->13).
- SERIAL=1: assert rst at the 4th BUSY cycle -> next edge out_valid=0, out_data=0, busy=0, in_ready=1 in the following cycle.
  - A fresh word then gives the correct result, with no residue from the aborted word.
